// File: rtl/clk_switch_ctrl.sv
// Sequencer for the glitch-free two-source clock mux: accepts source-change requests,
// drives the mux select and confirms the switch from the mux's per-source enable flops.
module clk_switch_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int DWELL_CYC   = 16,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  input  logic act0,
  input  logic act1,
  output logic sel,
  output logic cur_src,
  output logic busy,
  output logic done,
  output logic err
);

  typedef enum logic [2:0] {
    BOOT     = 3'd0,
    IDLE     = 3'd1,
    OFF_WAIT = 3'd2,
    ON_WAIT  = 3'd3,
    HOLD     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);

  state_t                 state_r;
  logic [CNT_W-1:0]       timer_r;
  logic [SYNC_STAGES-1:0] a0_sync_r;
  logic [SYNC_STAGES-1:0] a1_sync_r;
  logic                   sel_r;
  logic                   cur_src_r;
  logic                   done_r;
  logic                   err_r;

  logic                   a0_s;
  logic                   a1_s;
  logic                   old_act_s;
  logic                   new_act_s;
  logic                   tmo_s;
  logic [CNT_W-1:0]       timer_inc_s;

  assign a0_s        = a0_sync_r[SYNC_STAGES-1];
  assign a1_s        = a1_sync_r[SYNC_STAGES-1];
  assign old_act_s   = sel_r ? a0_s : a1_s;
  assign new_act_s   = sel_r ? a1_s : a0_s;
  // The OFF_WAIT exit keeps counting, so ON_WAIT may see the timer one past its last value.
  assign tmo_s       = (timer_r >= TMO_LAST);
  assign timer_inc_s = timer_r + CNT_W'(1);

  assign req_ready = (state_r == IDLE);
  assign busy      = (state_r != IDLE);
  assign sel       = sel_r;
  assign cur_src   = cur_src_r;
  assign done      = done_r;
  assign err       = err_r;

  // Synchronise the mux enable flops into the reference clock domain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a0_sync_r <= {SYNC_STAGES{1'b0}};
      a1_sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      a0_sync_r <= {a0_sync_r[SYNC_STAGES-2:0], act0};
      a1_sync_r <= {a1_sync_r[SYNC_STAGES-2:0], act1};
    end
  end

  // Switch sequencing FSM with shared timeout/dwell timer and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= BOOT;
      timer_r   <= {CNT_W{1'b0}};
      sel_r     <= 1'b0;
      cur_src_r <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        BOOT: begin
          if (a0_s) begin
            state_r <= IDLE;
            timer_r <= {CNT_W{1'b0}};
          end else if (tmo_s) begin
            err_r   <= 1'b1;
            state_r <= IDLE;
            timer_r <= {CNT_W{1'b0}};
          end else begin
            timer_r <= timer_inc_s;
          end
        end
        IDLE: begin
          if (req_valid) begin
            if (req_sel == cur_src_r) begin
              done_r <= 1'b1;
            end else begin
              sel_r   <= req_sel;
              timer_r <= {CNT_W{1'b0}};
              state_r <= OFF_WAIT;
            end
          end else begin
            timer_r <= {CNT_W{1'b0}};
          end
        end
        OFF_WAIT: begin
          if (!old_act_s) begin
            state_r <= ON_WAIT;
            timer_r <= timer_inc_s;
          end else if (tmo_s) begin
            err_r   <= 1'b1;
            state_r <= HOLD;
            timer_r <= {CNT_W{1'b0}};
          end else begin
            timer_r <= timer_inc_s;
          end
        end
        ON_WAIT: begin
          if (new_act_s) begin
            cur_src_r <= sel_r;
            done_r    <= 1'b1;
            state_r   <= HOLD;
            timer_r   <= {CNT_W{1'b0}};
          end else if (tmo_s) begin
            err_r   <= 1'b1;
            state_r <= HOLD;
            timer_r <= {CNT_W{1'b0}};
          end else begin
            timer_r <= timer_inc_s;
          end
        end
        HOLD: begin
          if (timer_r == DWELL_LAST) begin
            state_r <= IDLE;
            timer_r <= {CNT_W{1'b0}};
          end else begin
            timer_r <= timer_inc_s;
          end
        end
        default: begin
          state_r <= BOOT;
          timer_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Randomised bench for clk_switch_ctrl: event times of each switch are predicted
// arithmetically from the scripted mux enable waveforms and checked every cycle.
module tb_clk_switch_ctrl;

  localparam int S     = 2;
  localparam int T     = 64;
  localparam int DW    = 16;
  localparam int NEVER = 100000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_sel = 1'b0;
  logic act0 = 1'b0;
  logic act1 = 1'b0;
  logic req_ready, sel, cur_src, busy, done, err;
  logic [5:0] vec;

  int n_vec = 0;
  int n_err = 0;
  logic sel_m = 1'b0;
  logic cur_m = 1'b0;

  always #5 clk = ~clk;

  clk_switch_ctrl #(
    .SYNC_STAGES(S), .DWELL_CYC(DW), .TIMEOUT_CYC(T), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_sel(req_sel),
    .req_ready(req_ready), .act0(act0), .act1(act1), .sel(sel),
    .cur_src(cur_src), .busy(busy), .done(done), .err(err)
  );

  assign vec = {req_ready, busy, sel, cur_src, done, err};

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%b exp=%b (ready,busy,sel,cur_src,done,err)", tag, $time, got, exp);
    end
  endtask

  function automatic int imax(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  task automatic set_act(input logic idx, input logic v);
    if (idx) act1 = v;
    else act0 = v;
  endtask

  // Mux settled on the confirmed source.
  task automatic restore_acts();
    act0 = ~cur_m;
    act1 = cur_m;
  endtask

  task automatic idle_wait(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("idle", vec, {1'b1, 1'b0, sel_m, cur_m, 1'b0, 1'b0});
    end
  endtask

  // Reset, then act0 rises r cycles after release (r >= NEVER: never).
  task automatic do_boot(input int r);
    int x;
    logic berr;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    act0 = 1'b0;
    act1 = 1'b0;
    #1;
    check("rst_async", vec, 6'b010000);
    @(posedge clk); #1;
    check("rst_hold", vec, 6'b010000);
    @(negedge clk);
    rst = 1'b1;
    if (r == 0) act0 = 1'b1;
    berr = (r + S + 1 > T);
    x = berr ? T : r + S + 1;
    for (int k = 1; k <= x; k++) begin
      @(posedge clk); #1;
      if (k < x) check("boot", vec, 6'b010000);
      else       check("boot_exit", vec, {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, berr});
      if (k == r) act0 = 1'b1;
    end
    sel_m = 1'b0;
    cur_m = 1'b0;
    restore_acts();
    idle_wait(S + 2);
  endtask

  // One request. Old source enable falls a cycles after the accepting edge, new one
  // rises b cycles after it. pre>=0 raises a held request during HOLD; abort stops at cycle abort.
  task automatic run_req(input logic rs, input int a, input int b, input int pre,
                         input int abort, output bit aborted, output bit held);
    int off_e, d_e, lim, f;
    bit ok;
    logic cur0;
    aborted = 1'b0;
    held = 1'b0;
    req_valid = 1'b1;
    req_sel = rs;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (rs == cur_m) begin
      check("same_src", vec, {1'b1, 1'b0, sel_m, cur_m, 1'b1, 1'b0});
      return;
    end
    cur0 = cur_m;
    off_e = (a >= NEVER) ? NEVER : a + S + 1;
    if (off_e > T) begin
      f = T; ok = 1'b0;
    end else begin
      d_e = (b >= NEVER) ? NEVER : S + 1 + imax(b, a + 1);
      lim = imax(T, off_e + 1);
      if (d_e <= lim) begin f = d_e; ok = 1'b1; end
      else begin f = lim; ok = 1'b0; end
    end
    sel_m = rs;
    for (int k = 0; k <= f + DW; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      check("switch", vec, {(k == f + DW), (k != f + DW), rs,
                            (ok && k >= f) ? rs : cur0,
                            (ok && k == f), (!ok && k == f)});
      if (k == abort) begin
        aborted = 1'b1;
        return;
      end
      if (k < f) begin
        if (k == a) set_act(~rs, 1'b0);
        if (k == b) set_act(rs, 1'b1);
      end else if (k == f) begin
        if (ok) cur_m = rs;
        restore_acts();
        if (pre >= 0) begin
          req_valid = 1'b1;
          req_sel = pre[0];
          held = 1'b1;
        end
      end
    end
  endtask

  initial begin
    bit ab_f, held_f;
    int forced;
    int a, b, pre, ab;
    logic rs;

    // Boot with act0 rising three cycles after reset release
    do_boot(3);
    // Switch to clk1, then back to clk0, then a same-source request
    run_req(1'b1, 5, 9, -1, -1, ab_f, held_f);
    idle_wait(2);
    run_req(1'b0, 3, 7, -1, -1, ab_f, held_f);
    idle_wait(1);
    run_req(1'b0, NEVER, NEVER, -1, -1, ab_f, held_f);
    idle_wait(1);
    // act0 stuck high: timeout, with a same-source request held through HOLD
    run_req(1'b1, NEVER, NEVER, 0, -1, ab_f, held_f);
    run_req(1'b0, NEVER, NEVER, -1, -1, ab_f, held_f);
    idle_wait(2);
    // Reset while waiting for the new source
    run_req(1'b1, 2, NEVER, -1, 2 + S + 3, ab_f, held_f);
    do_boot(0);
    // Boot with act0 never rising
    do_boot(NEVER);

    forced = -1;
    for (int it = 0; it < 40; it++) begin
      rs  = (forced >= 0) ? forced[0] : 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 5) == 0) ? NEVER : int'($urandom_range(0, 66));
      b   = ($urandom_range(0, 5) == 0) ? NEVER : int'($urandom_range(0, 80));
      pre = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : -1;
      ab  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 30)) : -1;
      run_req(rs, a, b, pre, ab, ab_f, held_f);
      forced = -1;
      if (ab_f) begin
        do_boot(int'($urandom_range(0, 10)));
      end else if (held_f) begin
        forced = pre;
      end else begin
        idle_wait(int'($urandom_range(0, 3)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
